// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: plays CSR-loaded patterns onto the LED PIO data register
// through an Avalon-MM master, one pattern per programmed step period.
module led_pattern_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int DATA_W    = 10,
  parameter int PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq,
  output logic [1:0]  o_dbg_state
);

  localparam int SW = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_enable;
  logic                r_loop;
  logic                r_irq_en;
  logic                r_done;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic [4:0]          r_length;
  logic [DATA_W-1:0]   r_pat [NUM_STEPS];
  logic [DATA_W-1:0]   r_wdata;
  logic [SW-1:0]       r_step;

  logic                w_wr;
  logic                w_ctrl_wr;
  logic                w_stat_wr;
  logic                w_per_wr;
  logic                w_len_wr;
  logic                w_pat_sel;
  logic                w_pat_wr;
  logic                w_enable_nx;
  logic                w_loop_nx;
  logic [PERIOD_W-1:0] w_period_nx;
  logic [4:0]          w_length_nx;
  logic [4:0]          w_last_idx;
  logic                w_is_last;
  logic [PERIOD_W-1:0] w_cnt_load;
  logic                w_busy;
  logic                w_start;
  logic                w_accept;
  logic                w_advance;
  logic                w_wrap;
  logic                w_finish;
  logic [SW-1:0]       w_step_nx;
  logic                w_unused;

  // CSR decode
  assign w_wr      = s_chipselect & ~s_write_n;
  assign w_ctrl_wr = w_wr & (s_address == 5'd0);
  assign w_stat_wr = w_wr & (s_address == 5'd1);
  assign w_per_wr  = w_wr & (s_address == 5'd2);
  assign w_len_wr  = w_wr & (s_address == 5'd3);
  assign w_pat_sel = s_address[4] & ({1'b0, s_address[3:0]} < 5'(NUM_STEPS));
  assign w_pat_wr  = w_wr & w_pat_sel;
  assign w_unused  = ^s_writedata[31:PERIOD_W];

  // A CSR write landing in the same cycle as a step decision is seen by that decision
  assign w_enable_nx = w_ctrl_wr ? s_writedata[0] : r_enable;
  assign w_loop_nx   = w_ctrl_wr ? s_writedata[1] : r_loop;
  assign w_period_nx = w_per_wr ? s_writedata[PERIOD_W-1:0] : r_period;
  assign w_length_nx = w_len_wr ? s_writedata[4:0] : r_length;

  assign w_last_idx = (w_length_nx == 5'd0)          ? 5'd0 :
                      (w_length_nx > 5'(NUM_STEPS))  ? 5'(NUM_STEPS - 1) :
                                                       w_length_nx - 5'd1;
  assign w_is_last  = (5'(r_step) >= w_last_idx);
  assign w_cnt_load = (w_period_nx == '0) ? '0 : w_period_nx - 1'b1;
  assign w_busy     = (r_state != S_IDLE);
  assign w_step_nx  = (w_start | w_wrap) ? '0 : r_step + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_accept   = 1'b0;
    w_advance  = 1'b0;
    w_wrap     = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ctrl_wr && s_writedata[0]) begin
          w_start    = 1'b1;
          w_state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        // A started bus write always completes, even if disabled meanwhile
        if (!m_waitrequest) begin
          w_accept   = 1'b1;
          w_state_nx = w_enable_nx ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (!w_enable_nx) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == '0) begin
          if (!w_is_last) begin
            w_advance  = 1'b1;
            w_state_nx = S_WRITE;
          end else if (w_loop_nx) begin
            w_wrap     = 1'b1;
            w_state_nx = S_WRITE;
          end else begin
            w_finish   = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b0;
      r_loop   <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_period <= '0;
      r_length <= 5'd1;
      r_cnt    <= '0;
      r_step   <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_loop   <= s_writedata[1];
        r_irq_en <= s_writedata[2];
        if (r_state == S_IDLE)    r_enable <= s_writedata[0];
        else if (!s_writedata[0]) r_enable <= 1'b0;
      end
      if (w_finish) r_enable <= 1'b0;

      if (w_finish)                          r_done <= 1'b1;
      else if (w_start)                      r_done <= 1'b0;
      else if (w_stat_wr && s_writedata[1])  r_done <= 1'b0;

      if (w_per_wr) r_period <= s_writedata[PERIOD_W-1:0];
      if (w_len_wr) r_length <= s_writedata[4:0];

      // Pattern is captured on step entry so it stays stable through a stalled write
      if (w_start || w_advance || w_wrap) begin
        r_step  <= w_step_nx;
        r_wdata <= r_pat[w_step_nx];
      end

      if (w_accept)                                r_cnt <= w_cnt_load;
      else if (r_state == S_WAIT && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STEPS; i++) r_pat[i] <= '0;
    end else if (w_pat_wr) begin
      r_pat[s_address[SW-1:0]] <= s_writedata[DATA_W-1:0];
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      5'd0: s_readdata = {29'b0, r_irq_en, r_loop, r_enable};
      5'd1: s_readdata = {24'b0, 4'(r_step), 2'b0, r_done, w_busy};
      5'd2: s_readdata = 32'(r_period);
      5'd3: s_readdata = 32'(r_length);
      default: begin
        if (w_pat_sel) s_readdata = 32'(r_pat[s_address[SW-1:0]]);
      end
    endcase
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    if (r_state == S_WRITE) begin
      m_chipselect = 1'b1;
      m_write_n    = 1'b0;
      m_writedata  = 32'(r_wdata);
    end
  end

  assign m_address   = 2'b00;
  assign irq         = r_done & r_irq_en;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: randomized runs scored against
// a timeline model of the expected PIO write sequence.
module tb_led_pattern_sequencer;

  localparam int NUM_STEPS = 8;
  localparam int DATA_W    = 10;
  localparam int PERIOD_W  = 24;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        irq;
  logic [1:0]  o_dbg_state;

  led_pattern_sequencer #(
    .NUM_STEPS(NUM_STEPS), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .irq(irq), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] pat_m [NUM_STEPS];
  logic [31:0]       exp_q [$];
  int                exp_t [$];
  logic [31:0]       obs_d [$];
  int                obs_t [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // accepted PIO writes, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
      obs_d.push_back(m_writedata);
      obs_t.push_back(cyc);
      check_eq("m_address", 32'(m_address), 32'd0);
    end
  end

  // driver tasks
  task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
    s_address    = a;
    s_writedata  = d;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic csr_rd(input logic [4:0] a, output logic [31:0] d);
    s_address    = a;
    s_chipselect = 1'b1;
    #1;
    d = s_readdata;
    s_chipselect = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input int i, input logic [31:0] d);
    pat_m[i] = d[DATA_W-1:0];
    csr_wr(5'(16 + i), d);
  endtask

  task automatic load_random_pats();
    for (int i = 0; i < NUM_STEPS; i++) set_pat(i, $urandom());
  endtask

  task automatic clear_queues();
    obs_d.delete(); obs_t.delete(); exp_q.delete(); exp_t.delete();
  endtask

  // reference timeline: one write every eff_period+1 cycles from t0, cycling
  // through eff_length slots; stops after one pass, or before t_stop when looping
  task automatic build_exp(input int t0, input int p, input int l, input bit loop_en, input int t_stop);
    int t;
    for (int k = 0; k < 1000; k++) begin
      t = t0 + k * (p + 1);
      if (!loop_en && k >= l) break;
      if (loop_en && t >= t_stop) break;
      exp_q.push_back(32'(pat_m[k % l]));
      exp_t.push_back(t);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_eq({tag, "_nwr"}, 32'(obs_d.size()), 32'(exp_q.size()));
    n = (obs_d.size() < exp_q.size()) ? obs_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_data"}, obs_d[i], exp_q[i]);
      check_eq({tag, "_time"}, 32'(obs_t[i]), 32'(exp_t[i]));
    end
  endtask

  task automatic run_case(input string tag, input int period, input int length,
                          input bit loop_en, input bit irq_en, input int run_cycles);
    int p, l, t0, t_stop, n;
    logic [31:0] rd;
    p = (period == 0) ? 1 : period;
    l = (length == 0) ? 1 : ((length > NUM_STEPS) ? NUM_STEPS : length);
    csr_wr(5'd2, 32'(period));
    csr_wr(5'd3, 32'(length));
    clear_queues();
    csr_wr(5'd0, {29'b0, irq_en, loop_en, 1'b1});
    t0 = cyc;
    t_stop = 0;
    if (loop_en) begin
      wait_cyc(run_cycles);
      csr_wr(5'd0, {29'b0, irq_en, loop_en, 1'b0});
      t_stop = cyc;
      wait_cyc(p + 4);
    end else begin
      wait_cyc(l * (p + 1) + 4);
    end
    build_exp(t0, p, l, loop_en, t_stop);
    compare_writes(tag);
    n = exp_q.size();
    csr_rd(5'd1, rd);
    check_eq({tag, "_status"}, rd, (32'((n - 1) % l) << 4) | (loop_en ? 32'd0 : 32'd2));
    check_eq({tag, "_irq"}, 32'(irq), 32'(!loop_en && irq_en));
    csr_rd(5'd0, rd);
    check_eq({tag, "_ctrl"}, rd, {29'b0, irq_en, loop_en, 1'b0});
    if (!loop_en) begin
      csr_wr(5'd1, 32'h2);
      csr_rd(5'd1, rd);
      check_eq({tag, "_w1c"}, rd, 32'((n - 1) % l) << 4);
      check_eq({tag, "_irq_clr"}, 32'(irq), 32'd0);
    end
  endtask

  initial begin : main
    logic [31:0] rd;
    int t0;

    wait_cyc(3);
    check_eq("rst_cs", 32'(m_chipselect), 32'd0);
    check_eq("rst_wn", 32'(m_write_n), 32'd1);
    check_eq("rst_wd", m_writedata, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    wait_cyc(1);
    csr_rd(5'd1, rd); check_eq("rst_status", rd, 32'd0);
    csr_rd(5'd0, rd); check_eq("rst_ctrl", rd, 32'd0);
    csr_rd(5'd3, rd); check_eq("rst_length", rd, 32'd1);

    // register widths and unmapped addresses
    csr_wr(5'd2, 32'hFFFF_FFFF);
    csr_rd(5'd2, rd); check_eq("period_mask", rd, 32'h00FF_FFFF);
    csr_wr(5'd3, 32'hFFFF_FFFF);
    csr_rd(5'd3, rd); check_eq("length_mask", rd, 32'h1F);
    csr_wr(5'd5, 32'hDEAD_BEEF);
    csr_rd(5'd5, rd); check_eq("unmapped5", rd, 32'd0);
    csr_wr(5'd24, 32'h3FF);
    csr_rd(5'd24, rd); check_eq("unmapped24", rd, 32'd0);
    set_pat(3, 32'hFFFF_F2A5);
    csr_rd(5'd19, rd); check_eq("pat_mask", rd, 32'h2A5);

    // three-step one-shot with irq
    set_pat(0, 32'h001); set_pat(1, 32'h002); set_pat(2, 32'h004);
    run_case("basic", 3, 3, 1'b0, 1'b1, 0);

    // length clamps
    load_random_pats();
    run_case("len0", 2, 0, 1'b0, 1'b1, 0);
    load_random_pats();
    run_case("len31", 1, 31, 1'b0, 1'b0, 0);

    // looping, disabled mid-run
    load_random_pats();
    run_case("loop2", 0, 2, 1'b1, 1'b1, 20);
    load_random_pats();
    run_case("loop8", 1, 8, 1'b1, 1'b0, 30);

    for (int i = 0; i < 6; i++) begin
      load_random_pats();
      run_case("rand", $urandom_range(0, 4), $urandom_range(0, 12),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(3, 40));
    end

    // stalled write held for five cycles
    set_pat(0, 32'h155);
    m_waitrequest = 1'b1;
    csr_wr(5'd2, 32'd2);
    csr_wr(5'd3, 32'd1);
    clear_queues();
    csr_wr(5'd0, 32'h1);
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_cs", 32'(m_chipselect), 32'd1);
      check_eq("stall_wn", 32'(m_write_n), 32'd0);
      check_eq("stall_wd", m_writedata, 32'h155);
    end
    @(posedge clk); #1;
    m_waitrequest = 1'b0;
    wait_cyc(2);
    csr_rd(5'd1, rd); check_eq("stall_wait", rd, 32'h1);
    wait_cyc(1);
    csr_rd(5'd1, rd); check_eq("stall_done", rd, 32'h2);
    check_eq("stall_nwr", 32'(obs_d.size()), 32'd1);
    if (obs_t.size() > 0) begin
      check_eq("stall_time", 32'(obs_t[0]), 32'(t0 + 5));
      check_eq("stall_data", obs_d[0], 32'h155);
    end

    // asynchronous reset during an outstanding write
    set_pat(0, 32'h2AA);
    m_waitrequest = 1'b1;
    csr_wr(5'd0, 32'h5);
    #2;
    check_eq("pre_rst_cs", 32'(m_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_cs", 32'(m_chipselect), 32'd0);
    check_eq("arst_wn", 32'(m_write_n), 32'd1);
    check_eq("arst_wd", m_writedata, 32'd0);
    check_eq("arst_irq", 32'(irq), 32'd0);
    m_waitrequest = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    clear_queues();
    wait_cyc(10);
    check_eq("post_rst_nwr", 32'(obs_d.size()), 32'd0);
    csr_rd(5'd1, rd);  check_eq("post_rst_status", rd, 32'd0);
    csr_rd(5'd0, rd);  check_eq("post_rst_ctrl", rd, 32'd0);
    csr_rd(5'd3, rd);  check_eq("post_rst_length", rd, 32'd1);
    csr_rd(5'd16, rd); check_eq("post_rst_pat0", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
